// File: rtl/conv_kxk_pipelined.sv
// K*K window convolution: products, registered adder tree, shift/saturate; latency clog2(K*K)+2.
// A single global enable (!out_valid || out_ready) stalls every stage; coefficient loads never stall.
module conv_kxk_pipelined #(
    parameter int DATA_W         = 8,
    parameter int COEF_W         = 8,
    parameter int K              = 3,
    parameter int SHIFT          = 0,
    parameter int OUT_W          = 16,
    parameter int CLAMP_UNSIGNED = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [K*K*DATA_W-1:0]        in_window,
    input  logic                         coef_we,
    input  logic [$clog2(K*K)-1:0]       coef_addr,
    input  logic [COEF_W-1:0]            coef_data,
    input  logic                         coef_commit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic                         out_sat
);
    localparam int NN    = K * K;
    localparam int AW    = $clog2(NN);
    localparam int N     = $clog2(NN);
    localparam int PW    = DATA_W + COEF_W + 1;
    localparam int ACC_W = PW + N;
    localparam int CW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;

    function automatic int lvl_cnt(input int l);
        int c;
        c = NN;
        for (int i = 0; i < l; i++) c = (c + 1) / 2;
        return c;
    endfunction

    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int i = 0; i < l; i++) o += lvl_cnt(i);
        return o;
    endfunction

    // All tree levels live in one flat array; level l starts at lvl_off(l).
    localparam int NODES = lvl_off(N + 1);
    localparam int ROOT  = lvl_off(N);

    localparam logic signed [CW-1:0] ONE   = CW'(1);
    localparam logic signed [CW-1:0] S_MAX = (ONE <<< (OUT_W - 1)) - ONE;
    localparam logic signed [CW-1:0] S_MIN = -(ONE <<< (OUT_W - 1));
    localparam logic signed [CW-1:0] U_MAX = (ONE <<< OUT_W) - ONE;
    localparam logic signed [CW-1:0] HI    = (CLAMP_UNSIGNED != 0) ? U_MAX : S_MAX;
    localparam logic signed [CW-1:0] LO    = (CLAMP_UNSIGNED != 0) ? '0 : S_MIN;

    logic signed [COEF_W-1:0] shadow_q [NN];
    logic signed [COEF_W-1:0] active_q [NN];
    logic signed [ACC_W-1:0]  node_q   [NODES];
    logic [N:0]               vld_q;
    logic                     out_valid_q;
    logic [OUT_W-1:0]         out_data_q;
    logic                     out_sat_q;

    logic                     en;
    logic signed [PW-1:0]     prod_d [NN];
    logic signed [ACC_W-1:0]  shifted_d;
    logic signed [CW-1:0]     wide_d;
    logic [OUT_W-1:0]         out_data_d;
    logic                     out_sat_d;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Pixel zero-extended, coefficient sign-extended, both to the full product width.
    always_comb begin
        for (int j = 0; j < NN; j++) begin
            prod_d[j] = $signed({{(COEF_W + 1){1'b0}}, in_window[j*DATA_W +: DATA_W]})
                      * $signed({{(DATA_W + 1){active_q[j][COEF_W-1]}}, active_q[j]});
        end
    end

    always_comb begin
        shifted_d  = node_q[ROOT] >>> SHIFT;
        wide_d     = $signed({{(CW - ACC_W){shifted_d[ACC_W-1]}}, shifted_d});
        out_data_d = wide_d[OUT_W-1:0];
        out_sat_d  = 1'b0;
        if (wide_d > HI) begin
            out_data_d = HI[OUT_W-1:0];
            out_sat_d  = 1'b1;
        end else if (wide_d < LO) begin
            out_data_d = LO[OUT_W-1:0];
            out_sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NN; j++) begin
                shadow_q[j] <= (j == (NN - 1) / 2) ? COEF_W'(1) : '0;
                active_q[j] <= (j == (NN - 1) / 2) ? COEF_W'(1) : '0;
            end
            for (int n = 0; n < NODES; n++) node_q[n] <= '0;
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            // Commit reads shadow_q before this cycle's write lands.
            if (coef_we && (coef_addr < AW'(NN))) shadow_q[coef_addr] <= coef_data;
            if (coef_commit) begin
                for (int j = 0; j < NN; j++) active_q[j] <= shadow_q[j];
            end
            if (en) begin
                vld_q <= {vld_q[N-1:0], in_valid};
                for (int j = 0; j < NN; j++) begin
                    node_q[j] <= $signed({{N{prod_d[j][PW-1]}}, prod_d[j]});
                end
                for (int l = 1; l <= N; l++) begin
                    for (int j = 0; j < NN; j++) begin
                        if (j < lvl_cnt(l)) begin
                            if (2 * j + 1 < lvl_cnt(l - 1))
                                node_q[lvl_off(l) + j] <= node_q[lvl_off(l - 1) + 2 * j]
                                                        + node_q[lvl_off(l - 1) + 2 * j + 1];
                            else
                                node_q[lvl_off(l) + j] <= node_q[lvl_off(l - 1) + 2 * j];
                        end
                    end
                end
                out_valid_q <= vld_q[N];
                out_data_q  <= out_data_d;
                out_sat_q   <= out_sat_d;
            end
        end
    end
endmodule

// File: tb/tb_conv_kxk_pipelined.sv
// Bench for conv_kxk_pipelined: a signed-clamp and an unsigned-clamp instance share all inputs.
module tb_conv_kxk_pipelined;
    localparam int L = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready_s, in_ready_u;
    logic [71:0] in_window;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        coef_commit;
    logic        out_ready;
    logic        out_valid_s, out_valid_u;
    logic [15:0] out_data_s, out_data_u;
    logic        out_sat_s, out_sat_u;

    always #5 clk = ~clk;

    conv_kxk_pipelined #(.DATA_W(8), .COEF_W(8), .K(3), .SHIFT(0), .OUT_W(16), .CLAMP_UNSIGNED(0)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_window(in_window),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_sat(out_sat_s));

    conv_kxk_pipelined #(.DATA_W(8), .COEF_W(8), .K(3), .SHIFT(0), .OUT_W(16), .CLAMP_UNSIGNED(1)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .in_window(in_window),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u), .out_sat(out_sat_u));

    typedef struct {
        bit vld;
        int ds;
        bit ss;
        int du;
        bit su;
    } exp_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   inflight = 0;
    bit   armed = 0;
    bit   rand_ready = 0;
    exp_t pipe [L];
    int   shd [9];
    int   act [9];
    int   res_s [$];
    int   res_u [$];
    int   rsat_s [$];
    int   rsat_u [$];

    int lap [9]    = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    int box [9]    = '{default: 1};
    int all127 [9] = '{default: 127};
    int allm128[9] = '{default: -128};

    task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -999999;
    endfunction

    // Reference result straight from the arithmetic definition.
    function automatic exp_t predict(input bit v, input logic [71:0] w, input int k[9]);
        exp_t   e;
        longint s;
        s = 0;
        for (int j = 0; j < 9; j++) s += longint'(w[j*8 +: 8]) * longint'(k[j]);
        s = s >>> 0;
        e.vld = v;
        if (s > 32767)       begin e.ds = 32767;  e.ss = 1; end
        else if (s < -32768) begin e.ds = -32768; e.ss = 1; end
        else                 begin e.ds = int'(s); e.ss = 0; end
        if (s < 0)           begin e.du = 0;      e.su = 1; end
        else if (s > 65535)  begin e.du = 65535;  e.su = 1; end
        else                 begin e.du = int'(s); e.su = 0; end
        return e;
    endfunction

    function automatic logic [71:0] win_c(input int c, input int o);
        logic [71:0] w;
        for (int j = 0; j < 9; j++) w[j*8 +: 8] = 8'((j == 4) ? c : o);
        return w;
    endfunction

    function automatic logic [71:0] win_seq(input int b);
        logic [71:0] w;
        for (int j = 0; j < 9; j++) w[j*8 +: 8] = 8'((b * 37 + j * 11) % 256);
        return w;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        bit en;
        if (armed) begin
            en = !pipe[L-1].vld || out_ready;
            chk("in_ready_s", in_ready_s, en);
            chk("in_ready_u", in_ready_u, en);
            chk("out_valid_s", out_valid_s, pipe[L-1].vld);
            chk("out_valid_u", out_valid_u, pipe[L-1].vld);
            if (pipe[L-1].vld) begin
                chk("out_data_s", $signed(out_data_s), pipe[L-1].ds);
                chk("out_sat_s", out_sat_s, pipe[L-1].ss);
                chk("out_data_u", {1'b0, out_data_u}, pipe[L-1].du);
                chk("out_sat_u", out_sat_u, pipe[L-1].su);
                if (out_ready) begin
                    res_s.push_back(int'($signed(out_data_s)));
                    res_u.push_back(int'(out_data_u));
                    rsat_s.push_back(int'(out_sat_s));
                    rsat_u.push_back(int'(out_sat_u));
                end
            end
        end
        if (rst) begin
            for (int i = 0; i < L; i++) pipe[i].vld = 0;
            for (int j = 0; j < 9; j++) begin
                shd[j] = (j == 4) ? 1 : 0;
                act[j] = (j == 4) ? 1 : 0;
            end
            armed = 1;
        end else if (armed) begin
            en = !pipe[L-1].vld || out_ready;
            if (en) begin
                for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = predict(in_valid, in_window, act);
            end
            if (coef_commit) act = shd;
            if (coef_we && coef_addr < 9) shd[coef_addr] = int'($signed(coef_data));
        end
        inflight = 0;
        for (int i = 0; i < L; i++) inflight += int'(pipe[i].vld);
    end

    task automatic send(input logic [71:0] w);
        bit ok;
        ok = 0;
        in_valid  = 1'b1;
        in_window = w;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready_s) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (inflight == 0) break;
            @(negedge clk); #2;
        end
        chk("drain", inflight, 0);
        @(posedge clk); #1;
    endtask

    task automatic load(input int c[9], input bit commit);
        for (int i = 0; i < 9; i++) begin
            coef_we = 1'b1; coef_addr = 4'(i); coef_data = 8'(c[i]);
            @(posedge clk); #1;
        end
        coef_we = 1'b0;
        if (commit) begin
            coef_commit = 1'b1;
            @(posedge clk); #1;
            coef_commit = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n0;
        rst = 1'b1; in_valid = 1'b0; in_window = '0; coef_we = 1'b0; coef_addr = '0;
        coef_data = '0; coef_commit = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_s, 0);
        chk("rst_out_data", out_data_s, 0);
        chk("rst_in_ready", in_ready_s, 1);
        rst = 1'b0;

        // Identity kernel straight out of reset, with a latency probe on the first beat.
        n0 = res_s.size();
        send(win_c(0, 200));
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid_s) break;
        end
        chk("latency", cyc - acc_cyc, 6);
        @(posedge clk); #1;
        send(win_c(77, 3));
        send(win_c(255, 255));
        drain();
        chk("id_0", at(res_s, n0), 0);
        chk("id_77", at(res_s, n0 + 1), 77);
        chk("id_255", at(res_s, n0 + 2), 255);
        chk("id_255_sat", at(rsat_s, n0 + 2), 0);
        chk("id_255_u", at(res_u, n0 + 2), 255);

        // Laplacian.
        load(lap, 1);
        n0 = res_s.size();
        send(win_c(10, 10));
        send(win_c(50, 10));
        drain();
        chk("lap_flat", at(res_s, n0), 0);
        chk("lap_peak", at(res_s, n0 + 1), 320);

        // Commit in the acceptance cycle of beat n: n sees Laplacian, n+1 sees box.
        load(box, 0);
        n0 = res_s.size();
        in_valid = 1'b1; in_window = win_c(50, 10); coef_commit = 1'b1;
        @(negedge clk);
        chk("mid_ready", in_ready_s, 1);
        @(posedge clk); #1;
        coef_commit = 1'b0;
        send(win_c(50, 10));
        drain();
        chk("mid_old", at(res_s, n0), 320);
        chk("mid_new", at(res_s, n0 + 1), 130);

        // Saturation in both clamp modes.
        load(all127, 1);
        n0 = res_s.size();
        send(win_c(255, 255));
        load(allm128, 1);
        send(win_c(255, 255));
        drain();
        chk("sat_pos_s", at(res_s, n0), 32767);
        chk("sat_pos_s_flag", at(rsat_s, n0), 1);
        chk("sat_pos_u", at(res_u, n0), 65535);
        chk("sat_pos_u_flag", at(rsat_u, n0), 1);
        chk("sat_neg_s", at(res_s, n0 + 1), -32768);
        chk("sat_neg_s_flag", at(rsat_s, n0 + 1), 1);
        chk("sat_neg_u", at(res_u, n0 + 1), 0);
        chk("sat_neg_u_flag", at(rsat_u, n0 + 1), 1);

        // Ramp kernel; an out-of-range write, then a write coinciding with a commit.
        for (int i = 0; i < 8; i++) begin
            coef_we = 1'b1; coef_addr = 4'(i); coef_data = 8'(i - 4);
            @(posedge clk); #1;
        end
        coef_addr = 4'd12; coef_data = 8'd55;
        @(posedge clk); #1;
        coef_addr = 4'd8; coef_data = 8'd4; coef_commit = 1'b1;
        @(posedge clk); #1;
        coef_we = 1'b0;
        send(win_c(10, 10));
        @(posedge clk); #1;
        coef_commit = 1'b0;

        // Backpressure: 20 beats with random out_ready.
        drain();
        n0 = res_s.size();
        rand_ready = 1;
        for (int b = 0; b < 20; b++) send(win_seq(b));
        rand_ready = 0;
        drain();
        chk("bp_count", res_s.size(), n0 + 20);

        // Reset with four beats in flight.
        n0 = res_s.size();
        for (int b = 1; b <= 4; b++) send(win_c(b * 20, b));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_s", out_valid_s, 0);
        chk("rst_flush_u", out_valid_u, 0);
        @(posedge clk); #1;
        send(win_c(99, 7));
        drain();
        chk("rst_count", res_s.size(), n0 + 1);
        chk("rst_identity", at(res_s, n0), 99);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_kxk_pipelined.md
# conv_kxk_pipelined

Parametrised, fully pipelined K×K convolution engine for the image-processing datapath. Each accepted beat carries one flattened K×K pixel window; the block multiplies it against a run-time-loadable signed kernel, sums the products through a registered adder tree, then scales and saturates the result. It adds a valid/ready stream handshake, double-buffered coefficient loading and output saturation, none of which the fixed combinational 3×3 unit has.

## Interface
- DATA_W, 8, pixel width; pixels are unsigned
- COEF_W, 8, coefficient width; coefficients are signed two's complement
- K, 3, kernel side; legal values are 3, 5 and 7 (odd only)
- SHIFT, 0, arithmetic right shift applied to the sum before saturation
- OUT_W, 16, output width
- CLAMP_UNSIGNED, 0, selects the saturation mode: 0 clamps to signed OUT_W, 1 clamps to 0 .. 2^OUT_W−1
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  window beat valid
- in_ready  out  1  block can accept a beat
- in_window  in  K*K*DATA_W  pixel i sits at [i*DATA_W +: DATA_W], where i = row*K + col
- coef_we  in  1  write one coefficient into the shadow bank
- coef_addr  in  clog2(K*K)  shadow index, using the same mapping as the pixels
- coef_data  in  COEF_W  coefficient value
- coef_commit  in  1  copy the whole shadow bank into the active bank
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  saturated result (signed or unsigned per CLAMP_UNSIGNED)
- out_sat  out  1  the beat in out_data was clipped

## Operation
- Reset values:
  - All stage valid bits, out_valid, out_data and out_sat are 0.
  - Both coefficient banks reset to the identity kernel: index (K*K−1)/2 = 1, every other index = 0.
  - in_ready is 1 after reset.
- Datapath widths:
  - Each product is sized DATA_W+COEF_W+1 bits, signed, with the pixel zero-extended before the multiply.
  - The accumulator width is ACC_W = DATA_W + COEF_W + 1 + clog2(K*K). The tree cannot overflow.
- Pipeline stages:
  - Stage M registers all K*K products. Products are formed from in_window and the active bank in the acceptance cycle.
  - Stages A1..AN form a pairwise registered adder tree, with N = clog2(K*K). An odd operand passes through the level unchanged.
  - Stage S applies the SHIFT (arithmetic, floor) and saturation, then registers out_data and out_sat.
- Stall policy:
  - The pipeline uses a global enable, en = !out_valid || out_ready, and in_ready = en.
  - When en = 0 every stage holds, including its data and valid bits.
  - Bubbles are not compressed.
- Coefficient loading:
  - A coef_we writes the shadow bank only. The active bank is untouched.
  - A coef_addr ≥ K*K is ignored.
  - coef_commit copies shadow → active at the clock edge. If a beat is accepted in that same cycle, it uses the old active bank.
  - If coef_we and coef_commit are asserted in the same cycle, the commit copies the shadow contents as they were before that write.
  - Commit and write are accepted independently of en (coefficients never stall).
- In-flight data: a beat already in the pipeline is unaffected by later commits.
- Saturation:
  - Signed mode clamps to −2^(OUT_W−1) .. 2^(OUT_W−1)−1.
  - Unsigned mode clamps negative values to 0 and large values to 2^OUT_W−1.
  - out_sat = 1 exactly when clipping occurred.
- Reset mid-stream: synchronous reset discards all in-flight beats and restores the identity kernel in both banks.

## Timing
- Latency is L = N + 2 cycles from the acceptance edge to out_valid, when no stalls occur. With K = 3, L = 6.
- Throughput is one beat per cycle while out_ready = 1.
- Output hold: out_valid, out_data and out_sat stay stable while out_valid = 1 and out_ready = 0.
- Combinational paths:
  - in_ready depends combinationally on out_ready. This is the only combinational path through the block.
  - No combinational path exists from in_valid to out_valid.
- First use after reset: a beat accepted in the first cycle after rst deasserts is valid and uses the identity kernel.

## Test plan
- Reset identity:
  - Stimulus: stream windows whose centre pixel is 0, 77 and 255, with out_ready = 1.
  - Response: out_data = 0, 77, 255, each L = 6 cycles after acceptance, with out_sat = 0.
- Laplacian with commit:
  - Stimulus: load centre = 8, others = −1, then commit.
  - Response: an all-10 window → 0; centre 50 with others 10 → 320.
- Saturation:
  - Stimulus 1: all coefficients 127, all pixels 255. Response: 32767 with out_sat = 1.
  - Stimulus 2: all coefficients −128, all pixels 255. Response: −32768 with out_sat = 1.
  - Stimulus 3: repeat stimulus 2 with CLAMP_UNSIGNED = 1. Response: 0 with out_sat = 1.
- Backpressure:
  - Stimulus: push 20 consecutive beats while toggling out_ready randomly.
  - Response: all 20 results emerge in order, none dropped or duplicated, and held outputs stay stable while out_ready = 0.
- Commit mid-stream:
  - Stimulus: assert coef_commit in the same cycle as beat n is accepted.
  - Response: beat n uses the old kernel and beat n+1 uses the new kernel.
- Reset during traffic:
  - Stimulus: assert rst with 4 beats in flight.
  - Response: the next cycle has out_valid = 0, and no stale results appear afterwards.
  - Follow-up: a beat sent after reset returns its centre pixel (identity kernel restored).
